// File: rtl/spi_wishbone_bridge.sv
// SPI mode-0 slave to Wishbone classic master bridge for 32-bit burst access.
// Define SPIWB_FRAME_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES of SPI silence.
module spi_wishbone_bridge #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_spi_clk,
    input  logic        i_spi_mosi,
    input  logic        i_spi_cs,
    output logic        o_spi_miso,
    output logic [31:0] m_wb_adr_o,
    input  logic [31:0] m_wb_dat_i,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_we_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,
    output logic        m_wb_cyc_o,
    output logic        o_busy
);

    localparam logic [7:0] CMD_RD = 8'hA1;
    localparam logic [7:0] CMD_WR = 8'hA2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR0, ADDR1, ADDR2, ADDR3,
        LEN0, LEN1, RDATA, WDATA, FLUSH
    } state_t;

    state_t state, state_d;

    logic [2:0]  sclk_q, cs_q;
    logic [1:0]  mosi_q;
    logic        sclk_rise, sclk_fall, cs_fall, cs_s, mosi_s;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  rx_byte, tx_sh, tx_hold, next_byte;
    logic        byte_done, last_byte;

    logic        is_wr;
    logic [31:0] addr;
    logic [15:0] len, rx_cnt, ld_cnt;
    logic [15:0] len_next;

    logic [31:0] rd_word, rd_shift;
    logic        rd_vld, rd_req, ld_ev;
    logic [1:0]  ld_idx;

    logic [31:0] wr_buf, wr_word, wr_data;
    logic [1:0]  wr_cnt;
    logic [3:0]  wr_sel;
    logic [31:0] hold_dat;
    logic [3:0]  hold_sel;
    logic        hold_vld;
    logic        to_hit;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_s      = cs_q[1];
    assign mosi_s    = mosi_q[1];

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = sclk_rise & ~cs_s & (bit_cnt == 3'd7);
    assign last_byte = (rx_cnt + 16'd1) == len;
    assign len_next  = {len[7:0], rx_byte};

    assign ld_ev     = sclk_fall & ~cs_s & (bit_cnt == 3'd0)
                     & (state == RDATA) & (ld_cnt < len);
    assign rd_shift  = rd_word << {ld_idx, 3'b000};
    assign next_byte = (ld_ev && rd_vld) ? rd_shift[31:24] : 8'h00;

    // Partial words are left-justified so the valid bytes lead.
    assign wr_word   = {wr_buf[23:0], rx_byte};
    assign wr_data   = wr_word << {~wr_cnt, 3'b000};
    assign wr_sel    = 4'hF << ~wr_cnt;

    assign o_spi_miso = tx_sh[7];
    assign o_busy     = (state != IDLE);

`ifdef SPIWB_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;
    logic          cs_chg;

    assign cs_chg = cs_q[1] ^ cs_q[2];
    assign to_hit = (state != IDLE) && (state != FLUSH) && (to_cnt == TO_MAX);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            to_cnt <= '0;
        end else if (sclk_rise || sclk_fall || cs_chg) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) state <= IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (byte_done && (rx_byte == CMD_RD || rx_byte == CMD_WR))
                       state_d = ADDR0;
            ADDR0: if (byte_done) state_d = ADDR1;
            ADDR1: if (byte_done) state_d = ADDR2;
            ADDR2: if (byte_done) state_d = ADDR3;
            ADDR3: if (byte_done) state_d = LEN0;
            LEN0:  if (byte_done) state_d = LEN1;
            LEN1:  if (byte_done) begin
                       if (len_next == 16'd0) state_d = IDLE;
                       else if (is_wr)        state_d = WDATA;
                       else                   state_d = RDATA;
                   end
            RDATA, WDATA: if (byte_done && last_byte) state_d = FLUSH;
            FLUSH: if (!m_wb_cyc_o && !hold_vld && !rd_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (to_hit) state_d = FLUSH;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            sclk_q     <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            tx_hold    <= '0;
            is_wr      <= 1'b0;
            addr       <= '0;
            len        <= '0;
            rx_cnt     <= '0;
            ld_cnt     <= '0;
            ld_idx     <= '0;
            rd_word    <= '0;
            rd_vld     <= 1'b0;
            rd_req     <= 1'b0;
            wr_buf     <= '0;
            wr_cnt     <= '0;
            hold_dat   <= '0;
            hold_sel   <= '0;
            hold_vld   <= 1'b0;
            m_wb_adr_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_we_o  <= 1'b0;
            m_wb_sel_o <= '0;
            m_wb_stb_o <= 1'b0;
            m_wb_cyc_o <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], i_spi_clk};
            cs_q   <= {cs_q[1:0], i_spi_cs};
            mosi_q <= {mosi_q[0], i_spi_mosi};

            if (cs_s) begin
                bit_cnt <= '0;
                tx_sh   <= '0;
            end else begin
                if (sclk_rise) begin
                    rx_sh   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_sh   <= next_byte;
                        tx_hold <= next_byte;
                    end else begin
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end
                // Re-present the pending byte after the host toggles CS.
                if (cs_fall) tx_sh <= tx_hold;
            end

            if (m_wb_cyc_o) begin
                if (m_wb_ack_i || m_wb_err_i) begin
                    m_wb_cyc_o <= 1'b0;
                    m_wb_stb_o <= 1'b0;
                    if (!m_wb_we_o) begin
                        rd_word <= m_wb_err_i ? 32'h0 : m_wb_dat_i;
                        rd_vld  <= 1'b1;
                    end
                end
            end else if (hold_vld) begin
                m_wb_cyc_o <= 1'b1;
                m_wb_stb_o <= 1'b1;
                m_wb_we_o  <= 1'b1;
                m_wb_adr_o <= addr;
                m_wb_dat_o <= hold_dat;
                m_wb_sel_o <= hold_sel;
                addr       <= addr + 32'd4;
                hold_vld   <= 1'b0;
            end else if (rd_req) begin
                m_wb_cyc_o <= 1'b1;
                m_wb_stb_o <= 1'b1;
                m_wb_we_o  <= 1'b0;
                m_wb_adr_o <= addr;
                m_wb_sel_o <= 4'hF;
                addr       <= addr + 32'd4;
                rd_req     <= 1'b0;
            end

            if (byte_done) begin
                unique case (state)
                    IDLE: is_wr <= (rx_byte == CMD_WR);
                    ADDR0, ADDR1, ADDR2, ADDR3: addr <= {addr[23:0], rx_byte};
                    LEN0: len <= len_next;
                    LEN1: begin
                        len    <= len_next;
                        rx_cnt <= '0;
                        ld_cnt <= '0;
                        ld_idx <= '0;
                        rd_vld <= 1'b0;
                        wr_cnt <= '0;
                        if (!is_wr && len_next != 16'd0) rd_req <= 1'b1;
                    end
                    RDATA: rx_cnt <= rx_cnt + 16'd1;
                    WDATA: begin
                        rx_cnt <= rx_cnt + 16'd1;
                        wr_buf <= wr_word;
                        wr_cnt <= wr_cnt + 2'd1;
                        if (wr_cnt == 2'd3 || last_byte) begin
                            hold_dat <= wr_data;
                            hold_sel <= wr_sel;
                            hold_vld <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Prefetch the next word once the current word's last byte is out.
            if (ld_ev) begin
                ld_cnt <= ld_cnt + 16'd1;
                ld_idx <= ld_idx + 2'd1;
                if (ld_idx == 2'd3) begin
                    rd_vld <= 1'b0;
                    if ((ld_cnt + 16'd1) < len) rd_req <= 1'b1;
                end
            end

            if (to_hit) begin
                rd_req <= 1'b0;
                wr_cnt <= '0;
                wr_buf <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_wishbone_bridge.sv
// Directed bench for spi_wishbone_bridge with MISO and Wishbone scoreboards.
module tb_spi_wishbone_bridge;

    localparam int H = 80;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        miso;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic        we, stb, cyc, busy;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    bit          err_mode = 0;
    bit          fixed_en = 1;
    logic [31:0] fixed_dat = 32'hFFEEDDCC;
    bit          cs_toggle = 0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_t;

    wb_t         wb_q[$];
    logic [7:0]  mq[$];

    always #5 clk = ~clk;

    spi_wishbone_bridge dut (
        .i_clk      (clk),
        .i_resetn   (rstn),
        .i_spi_clk  (sclk),
        .i_spi_mosi (mosi),
        .i_spi_cs   (cs),
        .o_spi_miso (miso),
        .m_wb_adr_o (adr),
        .m_wb_dat_i (dat_i),
        .m_wb_dat_o (dat_o),
        .m_wb_we_o  (we),
        .m_wb_sel_o (sel),
        .m_wb_stb_o (stb),
        .m_wb_ack_i (ack),
        .m_wb_err_i (err),
        .m_wb_cyc_o (cyc),
        .o_busy     (busy)
    );

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {~a[7:0], a[7:0], 8'hA5, a[15:8]};
    endfunction

    function automatic logic [31:0] smask(logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave answers one cycle after stb with ack or err.
    always @(posedge clk) begin
        if (cyc && stb && !ack && !err) begin
            if (err_mode) err <= 1'b1;
            else          ack <= 1'b1;
            dat_i <= fixed_en ? fixed_dat : mem_word(adr);
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rstn && (cyc || stb)) check("cyc_stb", stb, cyc);
        if (rstn && cyc && stb && (ack || err)) begin
            check("wb_expected", wb_q.size() != 0, 1'b1);
            if (wb_q.size() != 0) begin
                wb_t e;
                e = wb_q.pop_front();
                check("wb_cycle",
                      {adr, we, sel, dat_o & (we ? smask(sel) : 32'h0)},
                      {e.adr, e.we, e.sel, e.dat & (e.we ? smask(e.sel) : 32'h0)});
            end
        end
    end

    task automatic exp_wb(logic [31:0] a, logic w, logic [3:0] s, logic [31:0] d);
        wb_t e;
        e.adr = a;
        e.we  = w;
        e.sel = s;
        e.dat = d;
        wb_q.push_back(e);
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] rx;
        mq.push_back(exp);
        @(negedge clk);
        if (cs) begin
            cs = 1'b0;
            #(H);
        end
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #(H);
            sclk = 1'b1;
            rx[i] = miso;
            #(H);
            sclk = 1'b0;
        end
        check($sformatf("miso_%02h", tx), rx, mq.pop_front());
        if (cs_toggle) begin
            #(H);
            cs = 1'b1;
            #(60);
        end
    endtask

    task automatic frame_end();
        #(H);
        cs = 1'b1;
        #(300);
    endtask

    task automatic hdr(logic [7:0] c, logic [31:0] a, logic [15:0] l);
        xfer(c, 8'h00);
        xfer(a[31:24], 8'h00);
        xfer(a[23:16], 8'h00);
        xfer(a[15:8], 8'h00);
        xfer(a[7:0], 8'h00);
        xfer(l[15:8], 8'h00);
        xfer(l[7:0], 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {miso, adr, dat_o, we, sel, stb, cyc, busy}, 73'h0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_after_reset", busy, 1'b0);

        // Junk byte in IDLE
        xfer(8'h5A, 8'h00);
        frame_end();
        check("junk_busy", busy, 1'b0);

        // Single-word read burst
        exp_wb(32'h11223344, 1'b0, 4'hF, 32'h0);
        xfer(8'hA1, 8'h00);
        #(H);
        check("busy_after_cmd", busy, 1'b1);
        xfer(8'h11, 8'h00);
        xfer(8'h22, 8'h00);
        xfer(8'h33, 8'h00);
        xfer(8'h44, 8'h00);
        xfer(8'h00, 8'h00);
        xfer(8'h04, 8'h00);
        xfer(8'h00, 8'hFF);
        xfer(8'h00, 8'hEE);
        xfer(8'h00, 8'hDD);
        xfer(8'h00, 8'hCC);
        frame_end();
        check("read_busy_drop", busy, 1'b0);
        check("read_wb_done", wb_q.size(), 0);

        // Single-word write, then trailing non-command bytes
        exp_wb(32'h11223344, 1'b1, 4'hF, 32'h55667788);
        hdr(8'hA2, 32'h11223344, 16'd4);
        xfer(8'h55, 8'h00);
        xfer(8'h66, 8'h00);
        xfer(8'h77, 8'h00);
        xfer(8'h88, 8'h00);
        xfer(8'h99, 8'h00);
        xfer(8'h00, 8'h00);
        frame_end();
        check("write_busy_drop", busy, 1'b0);
        check("write_wb_done", wb_q.size(), 0);

        // Full word plus 2-byte partial word
        exp_wb(32'h00000010, 1'b1, 4'hF, 32'h01020304);
        exp_wb(32'h00000014, 1'b1, 4'hC, 32'h05060000);
        hdr(8'hA2, 32'h00000010, 16'd6);
        for (int b = 1; b <= 6; b++) xfer(8'(b), 8'h00);
        frame_end();
        check("partial_busy_drop", busy, 1'b0);
        check("partial_wb_done", wb_q.size(), 0);

        // Zero-length frame
        hdr(8'hA1, 32'h00000000, 16'd0);
        frame_end();
        check("len0_busy", busy, 1'b0);
        check("len0_no_cycle", wb_q.size(), 0);

        // Read that errors returns zeros
        err_mode = 1;
        exp_wb(32'h00000020, 1'b0, 4'hF, 32'h0);
        hdr(8'hA1, 32'h00000020, 16'd4);
        for (int b = 0; b < 4; b++) xfer(8'h00, 8'h00);
        frame_end();
        err_mode = 0;
        check("err_busy_drop", busy, 1'b0);
        check("err_wb_done", wb_q.size(), 0);

        // Two-word read with CS toggled between bytes
        fixed_en  = 0;
        cs_toggle = 1;
        exp_wb(32'h00000100, 1'b0, 4'hF, 32'h0);
        exp_wb(32'h00000104, 1'b0, 4'hF, 32'h0);
        hdr(8'hA1, 32'h00000100, 16'd6);
        begin
            logic [31:0] w0, w1;
            w0 = mem_word(32'h100);
            w1 = mem_word(32'h104);
            xfer(8'h00, w0[31:24]);
            xfer(8'h00, w0[23:16]);
            xfer(8'h00, w0[15:8]);
            xfer(8'h00, w0[7:0]);
            xfer(8'h00, w1[31:24]);
            xfer(8'h00, w1[23:16]);
        end
        cs_toggle = 0;
        frame_end();
        check("toggle_busy_drop", busy, 1'b0);
        check("toggle_wb_done", wb_q.size(), 0);

        // CS pulse mid-byte restarts the byte
        @(negedge clk);
        cs = 1'b0;
        #(H);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #(H);
            sclk = 1'b1;
            #(H);
            sclk = 1'b0;
        end
        cs = 1'b1;
        #(100);
        exp_wb(32'h00000040, 1'b1, 4'h8, 32'hAB000000);
        hdr(8'hA2, 32'h00000040, 16'd1);
        xfer(8'hAB, 8'h00);
        frame_end();
        check("pulse_busy_drop", busy, 1'b0);
        check("pulse_wb_done", wb_q.size(), 0);
        check("miso_q_empty", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_wishbone_bridge.md
Name: spi_wishbone_bridge

Overview:
SPI slave (mode 0, MSB first) to Wishbone classic master bridge. Lets an external SPI host (Pi Zero) issue burst reads and writes of 32-bit words on the FPGA's internal Wishbone bus. SPI pins are oversampled in the i_clk domain, so there is no separate SPI clock domain in the RTL.

Parameters:
TIMEOUT_CYCLES, 65535, i_clk cycles of SPI inactivity before frame abort (used only with the optional feature).

Ports:
i_clk  in  1  system clock; must be at least 8x the SPI clock frequency.
i_resetn  in  1  asynchronous active-low reset.
i_spi_clk  in  1  SPI SCLK (CPOL=0).
i_spi_mosi  in  1  SPI data from host.
i_spi_cs  in  1  SPI chip select, active low.
o_spi_miso  out  1  SPI data to host; 0 when CS is high (not tri-stated).
m_wb_adr_o  out  32  Wishbone byte address.
m_wb_dat_i  in  32  Wishbone read data.
m_wb_dat_o  out  32  Wishbone write data.
m_wb_we_o  out  1  Wishbone write enable.
m_wb_sel_o  out  4  Wishbone byte select; sel[3] selects bits 31:24.
m_wb_stb_o  out  1  Wishbone strobe.
m_wb_ack_i  in  1  Wishbone acknowledge.
m_wb_err_i  in  1  Wishbone error.
m_wb_cyc_o  out  1  Wishbone cycle.
o_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; bit counter 0; registers cleared.
  - Reset mid-frame aborts the frame and any Wishbone cycle immediately.
- SPI synchronisation:
  - SCLK, CS and MOSI each pass through a 2-flop synchroniser with edge detect.
  - MOSI is sampled on the SCLK rising edge; MISO updates on the falling edge.
  - A byte completes after 8 rising edges with CS low.
  - CS high resets the bit counter and the MISO shifter only. Frame state persists, so the host may toggle CS between bytes.
- Frame format (all multi-byte fields big-endian):
  - CMD byte: 0xA1 = read, 0xA2 = write.
  - ADDR: 4 bytes.
  - LEN: 2 bytes, a byte count.
  - DATA: LEN bytes.
- States: IDLE, ADDR0-3, LEN0-1, then RDATA or WDATA, with WB_RD/WB_WR sub-cycles.
- IDLE:
  - Any byte other than 0xA1 or 0xA2 is ignored; the bridge stays in IDLE.
  - A valid CMD byte sets o_busy.
- LEN = 0: frame ends after LEN1 and returns to IDLE; no Wishbone traffic.
- Read frame:
  - On LEN1 completion, issue a read at ADDR with sel 0xF.
  - Each returned word is loaded as 4 bytes, MSB first (0xFFEEDDCC yields FF, EE, DD, CC).
  - The next word (ADDR+4) is prefetched when the last byte of the current word is loaded into the shifter.
  - After LEN bytes have shifted out: return to IDLE and drop o_busy.
  - For a partial last word, a full word is still read and the unused bytes are not sent.
- Write frame:
  - Bytes are packed MSB first into a 32-bit buffer.
  - After every 4th byte, issue a write at the current address with sel 0xF, then advance the address by 4.
  - A partial final word (LEN mod 4 != 0) is written with sel covering only the leading bytes, e.g. 2 bytes gives sel 0xC.
  - The next byte may be received while a write cycle is in progress; use a one-word holding buffer.
- MISO contents:
  - 0x00 during CMD, ADDR and LEN bytes.
  - 0x00 during write DATA bytes.
  - Read data during read DATA bytes.
- Wishbone handshake:
  - cyc and stb rise together.
  - adr, dat_o, we and sel are stable while stb is high.
  - stb and cyc drop on the cycle after ack or err is sampled high. There is no back-to-back pipelining; cyc is low for at least 1 cycle between transfers.
  - Slave must respond within 4 i_clk cycles to meet SPI timing. A late read substitutes 0x00 for that byte.
  - On err: for a read, data for that word is 0x00; for a write, the word is dropped. The frame continues either way.
- o_busy: high from CMD acceptance until the final Wishbone cycle completes and the frame is in IDLE.
- Address wraps modulo 2^32.
- Extra bytes after a frame completes are parsed as new CMD bytes in IDLE; non-commands are ignored.

Optional Feature:
SPIWB_FRAME_TIMEOUT_EN
- Defined: a counter clears on every SCLK edge and every CS change. If the frame is not in IDLE and the counter reaches TIMEOUT_CYCLES:
  - the frame aborts to IDLE and o_busy drops;
  - any active Wishbone cycle finishes normally first;
  - a partially collected write word is discarded.
- Undefined: no timeout; a frame waits indefinitely for its bytes.

Test Plan:
- Reset: hold i_resetn low -> all outputs 0, o_busy 0; release -> o_busy stays 0.
- Read burst: send A1 11 22 33 44 00 04, then 4 dummy bytes, with the slave returning 0xFFEEDDCC -> one read cycle at adr 0x11223344, we 0, sel 0xF; MISO data bytes FF EE DD CC; o_busy drops after byte 4.
- Write burst: send A2 11 22 33 44 00 04 55 66 77 88 -> one write at 0x11223344, dat_o 0x55667788, sel 0xF, we 1; trailing bytes 99 00 are ignored in IDLE and cause no cycle.
- Multi-word and partial write: send A2 00 00 00 10 00 06 01..06 -> write 0x01020304 at 0x10 with sel 0xF, then 0x0506xxxx at 0x14 with sel 0xC.
- Edge cases:
  - LEN 0 -> no Wishbone cycle.
  - Junk byte 0x5A in IDLE -> ignored, o_busy stays 0.
  - err on a read -> data bytes 00 00 00 00 and the frame completes.
- CS toggled high between every byte -> frame still decodes correctly; a CS pulse mid-byte restarts that byte.
